sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: extra SRAM wait cycles per 16-bit half access (range 0..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port wr_en  input  1  memory write request from the MEM stage.
REQ-005 SHALL have port rd_en  input  1  memory read request from the MEM stage.
REQ-006 SHALL have port address  input  32  byte address; only bits [18:2] are used.
REQ-007 SHALL have port write_data  input  32  store data.
REQ-008 SHALL have port read_data  output  32  load data, registered.
REQ-009 SHALL have port ready  output  1  high when no access is pending or the current access completes this cycle; pipeline freezes while low.
REQ-010 SHALL have port sram_addr  output  18  half-word address = {word index, half select}.
REQ-011 SHALL have port sram_dq_out  output  16  data driven to SRAM.
REQ-012 SHALL have port sram_dq_oe  output  1  tri-state enable for sram_dq_out.
REQ-013 SHALL have port sram_dq_in  input  16  data returned from SRAM.
REQ-014 SHALL have port sram_we_n  output  1  active-low SRAM write strobe.

Function
REQ-015 SHALL implement FSM states IDLE, LOW, HIGH, DONE.
REQ-016 In IDLE with wr_en or rd_en high: latch address[18:2], write_data and op; next state LOW; counter cleared.
REQ-017 wr_en and rd_en both high: SHALL perform a write; rd_en ignored.
REQ-018 LOW and HIGH SHALL each last exactly WAIT_CYCLES+1 cycles, timed by a 4-bit counter cleared on each phase entry.
REQ-019 sram_addr SHALL be {latched[18:2], 1'b0} in LOW, {latched[18:2], 1'b1} in HIGH, all-zero in IDLE and DONE.
REQ-020 Write: in LOW and HIGH, sram_we_n=0 and sram_dq_oe=1; sram_dq_out = write_data[15:0] in LOW and write_data[31:16] in HIGH.
REQ-021 Read: sram_we_n=1, sram_dq_oe=0; sram_dq_in sampled on the last cycle of LOW into read_data[15:0] and on the last cycle of HIGH into read_data[31:16].
REQ-022 IDLE, DONE: sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
REQ-023 Last cycle of HIGH: next state DONE; DONE always returns to IDLE after one cycle.
REQ-024 ready SHALL be 1 in IDLE with no request, 0 in IDLE with a request and in LOW and HIGH, and 1 in DONE.
REQ-025 Latency: ready rises exactly 2*(WAIT_CYCLES+1)+1 cycles after the request is first seen in IDLE (5 cycles at WAIT_CYCLES=1).
REQ-026 Requester SHALL hold the request and operands stable until ready=1; changes on address, write_data, rd_en or wr_en after acceptance SHALL NOT affect the access in flight.
REQ-027 A request still high in DONE SHALL NOT start a new access in DONE; a request present in the following IDLE cycle is a new access.
REQ-028 read_data SHALL change only during reads; writes and idle cycles hold its last value.
REQ-029 No request in IDLE: state stays IDLE; no SRAM strobes.

Reset
REQ-030 rst high at a clock edge: next state IDLE, counter 0, latched registers 0, read_data 0, sram_we_n 1, sram_dq_oe 0, sram_addr 0, ready 1.
REQ-031 rst asserted during LOW or HIGH SHALL abort the access; no further strobe after that edge; read_data is not partially retained.
REQ-032 rst SHALL take priority over any request sampled at the same edge.

Verification
REQ-033 Write, address 0x0000_0408, data 0xDEAD_BEEF, WAIT_CYCLES=1 -> sram_addr 0x00204 with dq 0xBEEF for 2 cycles, then 0x00205 with dq 0xDEAD for 2 cycles, we_n low for those 4 cycles, ready high 5 cycles after the request.
REQ-034 Read, address 0x0000_0408, SRAM model returns 0xBEEF/0xDEAD -> read_data = 0xDEADBEEF when ready=1; a subsequent write leaves read_data unchanged.
REQ-035 wr_en=rd_en=1 simultaneously -> write sequence performed, read_data unchanged.
REQ-036 rst pulsed in the second cycle of HIGH during a write -> we_n=1, oe=0, ready=1, read_data=0 on the following cycle; the next request runs full latency.
REQ-037 Back-to-back requests held through DONE, then the next request presented in IDLE -> exactly two accesses, each 6 cycles including IDLE, no strobe in DONE.
REQ-038 WAIT_CYCLES=0 -> each phase 1 cycle; ready high 3 cycles after the request.

Source files
------------

// File: rtl/sram_ctrl.sv
// Bridges a single-cycle 32-bit MEM-stage request onto a 16-bit asynchronous SRAM.
// Each access runs as a low half then a high half, and the pipeline is stalled through ready.
module sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n,
    output logic [1:0]  fsm_state
);

    // Request/stall handshake: the requester raises wr_en or rd_en with its operands
    // and keeps them stable until it sees ready=1. The controller captures everything
    // when it accepts in IDLE, so later changes to the inputs do not affect the access.
    // ready=1 in DONE marks completion. A request still present in DONE is only
    // accepted in the following IDLE cycle.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [16:0] addr_q;
    logic [31:0] data_q;
    logic        write_q;

    logic        req;
    logic        accept;
    logic        phase_last;
    logic        sample_lo;
    logic        sample_hi;
    logic        unused_addr_bits;

    assign req        = wr_en | rd_en;
    assign accept     = (state == IDLE) && req;
    assign phase_last = (cnt == LAST_CNT);
    assign sample_lo  = (state == LOW)  && !write_q && phase_last;
    assign sample_hi  = (state == HIGH) && !write_q && phase_last;
    assign fsm_state  = state;

    // Only the word index selects SRAM storage; the byte offset and upper bits are ignored.
    assign unused_addr_bits = ^{address[31:19], address[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            write_q   <= 1'b0;
            read_data <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                addr_q  <= address[18:2];
                data_q  <= write_data;
                write_q <= wr_en;
            end
            if (sample_lo) begin
                read_data[15:0] <= sram_dq_in;
            end
            if (sample_hi) begin
                read_data[31:16] <= sram_dq_in;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (req) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                if (phase_last) begin
                    state_next = HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Strobes come straight from the registered state so they change only on clock edges.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        ready       = 1'b0;
        case (state)
            IDLE: begin
                ready = !req;
            end
            LOW: begin
                sram_addr = {addr_q, 1'b0};
                if (write_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = data_q[15:0];
                end
            end
            HIGH: begin
                sram_addr = {addr_q, 1'b1};
                if (write_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = data_q[31:16];
                end
            end
            DONE: begin
                ready = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: one instance with one wait cycle behind a small SRAM model,
// and one instance with zero wait cycles behind an address-derived data pattern.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready, sram_dq_oe, sram_we_n;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic [1:0]  fsm_state;

    logic        wr_en_z, rd_en_z;
    logic [31:0] address_z, write_data_z, read_data_z;
    logic        ready_z, sram_dq_oe_z, sram_we_n_z;
    logic [17:0] sram_addr_z;
    logic [15:0] sram_dq_out_z, sram_dq_in_z;
    logic [1:0]  fsm_state_z;

    sram_ctrl #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .fsm_state(fsm_state)
    );

    sram_ctrl #(.WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .wr_en(wr_en_z), .rd_en(rd_en_z), .address(address_z),
        .write_data(write_data_z), .read_data(read_data_z), .ready(ready_z),
        .sram_addr(sram_addr_z), .sram_dq_out(sram_dq_out_z), .sram_dq_oe(sram_dq_oe_z),
        .sram_dq_in(sram_dq_in_z), .sram_we_n(sram_we_n_z), .fsm_state(fsm_state_z)
    );

    // Asynchronous SRAM model with a preload port used only while the controller is idle.
    logic [15:0] mem [4096];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [15:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (!sram_we_n) mem[sram_addr[11:0]] <= sram_dq_out;
    end
    assign sram_dq_in   = mem[sram_addr[11:0]];
    assign sram_dq_in_z = sram_addr_z[15:0] ^ 16'h5A5A;

    // Scoreboard: one entry per cycle = {dq_care, ready, we_n, oe, addr, dq_out, read_data}.
    logic [69:0] exp_q[$];
    logic [15:0] shadow [4096];
    logic [31:0] rd_main, rd_z;
    int          vectors = 0;
    int          fails = 0;

    function automatic logic [68:0] obs_main();
        return {ready, sram_we_n, sram_dq_oe, sram_addr, sram_dq_out, read_data};
    endfunction

    function automatic logic [68:0] obs_z();
        return {ready_z, sram_we_n_z, sram_dq_oe_z, sram_addr_z, sram_dq_out_z, read_data_z};
    endfunction

    function automatic logic [68:0] mask_of(input logic [69:0] e);
        return {21'h1F_FFFF, (e[69] ? 16'hFFFF : 16'h0000), 32'hFFFF_FFFF};
    endfunction

    // Expected cycles of one access, starting with the IDLE cycle that sees the request.
    task automatic push_access(input int wc, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [15:0] lo, input logic [15:0] hi,
                               input logic [31:0] rd_in, output logic [31:0] rd_out);
        logic [16:0] wi;
        logic [31:0] mid;
        wi  = a[18:2];
        mid = wr ? rd_in : {rd_in[31:16], lo};
        exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 18'd0, 16'd0, rd_in});
        for (int k = 0; k <= wc; k++)
            exp_q.push_back({wr, 1'b0, ~wr, wr, {wi, 1'b0}, (wr ? d[15:0] : 16'd0), rd_in});
        for (int k = 0; k <= wc; k++)
            exp_q.push_back({wr, 1'b0, ~wr, wr, {wi, 1'b1}, (wr ? d[31:16] : 16'd0), mid});
        rd_out = wr ? rd_in : {hi, lo};
        exp_q.push_back({1'b1, 1'b1, 1'b1, 1'b0, 18'd0, 16'd0, rd_out});
    endtask

    task automatic shadow_write(input logic [31:0] a, input logic [31:0] d);
        shadow[{a[12:2], 1'b0}] = d[15:0];
        shadow[{a[12:2], 1'b1}] = d[31:16];
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = {a[12:2], 1'b0}; pl_data = d[15:0];
        @(posedge clk); #1;
        pl_addr = {a[12:2], 1'b1}; pl_data = d[31:16];
        @(posedge clk); #1;
        pl_en = 1'b0;
        shadow_write(a, d);
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        wr_en_z = 1'b0; rd_en_z = 1'b0; address_z = '0; write_data_z = '0; pl_en = 1'b0;
        pl_addr = '0; pl_data = '0;
        repeat (3) @(posedge clk);
        #1;
        // A request at the same edge as reset must be dropped.
        wr_en = 1'b1; address = 32'h0000_0408; write_data = 32'h1111_2222; wr_en_z = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wr_en = 1'b0; wr_en_z = 1'b0;
        rd_main = '0; rd_z = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (obs_main() !== {1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 32'd0}) begin
                fails++;
                $display("FAIL reset_idle cyc%0d got %h want %h", i, obs_main(),
                         {1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 32'd0});
            end
            vectors++;
            if (obs_z() !== {1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 32'd0}) begin
                fails++;
                $display("FAIL reset_idle_w0 cyc%0d got %h want %h", i, obs_z(),
                         {1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 32'd0});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_write();
        logic [31:0] av [2];
        logic [31:0] dv [2];
        logic [69:0] e;
        logic [68:0] o;
        int n;
        av[0] = 32'h0000_0408; dv[0] = 32'hDEAD_BEEF;
        av[1] = 32'hFFF7_FFFF; dv[1] = 32'h0123_4567;
        for (int t = 0; t < 2; t++) begin
            wr_en = 1'b1; rd_en = 1'b0; address = av[t]; write_data = dv[t];
            push_access(1, 1'b1, av[t], dv[t], 16'd0, 16'd0, rd_main, rd_main);
            shadow_write(av[t], dv[t]);
            n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                e = exp_q.pop_front();
                o = obs_main();
                vectors++;
                if ((o & mask_of(e)) !== (e[68:0] & mask_of(e))) begin
                    fails++;
                    $display("FAIL write%0d cyc%0d got %h want %h", t, i, o, e[68:0]);
                end
                @(posedge clk); #1;
            end
            wr_en = 1'b0;
        end
    endtask

    task automatic test_read();
        logic [31:0] av [3];
        logic        wv [3];
        logic [69:0] e;
        logic [68:0] o;
        int n;
        preload(32'h0000_0408, 32'hDEAD_BEEF);
        preload(32'h0000_0C14, 32'h9BDF_1357);
        av[0] = 32'h0000_0408; wv[0] = 1'b0;
        av[1] = 32'h0000_0408; wv[1] = 1'b1;
        av[2] = 32'h0000_0C14; wv[2] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            wr_en = wv[t]; rd_en = ~wv[t]; address = av[t]; write_data = 32'h1234_5678;
            push_access(1, wv[t], av[t], 32'h1234_5678, shadow[{av[t][12:2], 1'b0}],
                        shadow[{av[t][12:2], 1'b1}], rd_main, rd_main);
            if (wv[t]) shadow_write(av[t], 32'h1234_5678);
            n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                e = exp_q.pop_front();
                o = obs_main();
                vectors++;
                if ((o & mask_of(e)) !== (e[68:0] & mask_of(e))) begin
                    fails++;
                    $display("FAIL read%0d cyc%0d got %h want %h", t, i, o, e[68:0]);
                end
                @(posedge clk); #1;
            end
            wr_en = 1'b0; rd_en = 1'b0;
        end
    endtask

    task automatic test_both();
        logic [69:0] e;
        logic [68:0] o;
        int n;
        wr_en = 1'b1; rd_en = 1'b1; address = 32'h0000_0C14; write_data = 32'h5555_AAAA;
        push_access(1, 1'b1, address, write_data, 16'd0, 16'd0, rd_main, rd_main);
        shadow_write(address, write_data);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs_main();
            vectors++;
            if ((o & mask_of(e)) !== (e[68:0] & mask_of(e))) begin
                fails++;
                $display("FAIL both_en cyc%0d got %h want %h", i, o, e[68:0]);
            end
            @(posedge clk); #1;
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [69:0] e;
        logic [68:0] o;
        int n;
        wr_en = 1'b1; rd_en = 1'b0; address = 32'h0000_0030; write_data = 32'hCAFE_F00D;
        push_access(1, 1'b1, address, write_data, 16'd0, 16'd0, rd_main, rd_main);
        push_access(1, 1'b1, address, write_data, 16'd0, 16'd0, rd_main, rd_main);
        shadow_write(address, write_data);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs_main();
            vectors++;
            if ((o & mask_of(e)) !== (e[68:0] & mask_of(e))) begin
                fails++;
                $display("FAIL b2b cyc%0d got %h want %h", i, o, e[68:0]);
            end
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs_main() !== {1'b1, 1'b1, 1'b0, 18'd0, 16'd0, rd_main}) begin
            fails++;
            $display("FAIL b2b_after got %h want %h", obs_main(),
                     {1'b1, 1'b1, 1'b0, 18'd0, 16'd0, rd_main});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        logic [69:0] e;
        logic [68:0] o;
        int n;
        wr_en = 1'b1; rd_en = 1'b0; address = 32'h0000_0100; write_data = 32'hA5A5_5A5A;
        push_access(1, 1'b1, address, write_data, 16'd0, 16'd0, rd_main, rd_main);
        // Reset lands on the second HIGH cycle of the write.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs_main();
            vectors++;
            if ((o & mask_of(e)) !== (e[68:0] & mask_of(e))) begin
                fails++;
                $display("FAIL abort_pre cyc%0d got %h want %h", i, o, e[68:0]);
            end
            @(posedge clk); #1;
            if (i == 3) begin rst = 1'b1; wr_en = 1'b0; end
            if (i == 4) rst = 1'b0;
        end
        exp_q.delete();
        rd_main = '0; rd_z = '0;
        @(negedge clk);
        vectors++;
        if (obs_main() !== {1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 32'd0}) begin
            fails++;
            $display("FAIL abort_post got %h want %h", obs_main(),
                     {1'b1, 1'b1, 1'b0, 18'd0, 16'd0, 32'd0});
        end
        @(posedge clk); #1;
        rd_en = 1'b1; address = 32'h0000_0408;
        push_access(1, 1'b0, address, 32'd0, shadow[{address[12:2], 1'b0}],
                    shadow[{address[12:2], 1'b1}], rd_main, rd_main);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            o = obs_main();
            vectors++;
            if ((o & mask_of(e)) !== (e[68:0] & mask_of(e))) begin
                fails++;
                $display("FAIL abort_next cyc%0d got %h want %h", i, o, e[68:0]);
            end
            @(posedge clk); #1;
        end
        rd_en = 1'b0;
    endtask

    task automatic test_wait0();
        logic [31:0] av [2];
        logic        wv [2];
        logic [17:0] h;
        logic [69:0] e;
        logic [68:0] o;
        int n;
        av[0] = 32'h0000_0020; wv[0] = 1'b1;
        av[1] = 32'h0000_0044; wv[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            wr_en_z = wv[t]; rd_en_z = ~wv[t]; address_z = av[t]; write_data_z = 32'h0F0F_F0F0;
            h = {av[t][18:2], 1'b0};
            push_access(0, wv[t], av[t], 32'h0F0F_F0F0, h[15:0] ^ 16'h5A5A,
                        (h[15:0] | 16'h0001) ^ 16'h5A5A, rd_z, rd_z);
            n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                e = exp_q.pop_front();
                o = obs_z();
                vectors++;
                if ((o & mask_of(e)) !== (e[68:0] & mask_of(e))) begin
                    fails++;
                    $display("FAIL wait0_%0d cyc%0d got %h want %h", t, i, o, e[68:0]);
                end
                @(posedge clk); #1;
            end
            wr_en_z = 1'b0; rd_en_z = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [31:0] addrs[$];
        logic [69:0] e;
        logic [68:0] o;
        int n;
        for (int t = 0; t < 16; t++) begin
            logic        wr;
            logic [31:0] a, d;
            wr = (addrs.size() == 0) || ($urandom_range(0, 1) == 1);
            if (wr) begin
                a = $urandom;
                a[18:2] = 17'($urandom_range(0, 2047));
                addrs.push_back(a);
            end else begin
                a = addrs[$urandom_range(0, addrs.size() - 1)];
                a[31:19] = 13'($urandom);
                a[1:0] = 2'($urandom);
            end
            d = $urandom;
            wr_en = wr; rd_en = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            address = a; write_data = d;
            push_access(1, wr, a, d, shadow[{a[12:2], 1'b0}], shadow[{a[12:2], 1'b1}],
                        rd_main, rd_main);
            if (wr) shadow_write(a, d);
            n = exp_q.size();
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                e = exp_q.pop_front();
                o = obs_main();
                vectors++;
                if ((o & mask_of(e)) !== (e[68:0] & mask_of(e))) begin
                    fails++;
                    $display("FAIL random%0d cyc%0d got %h want %h", t, i, o, e[68:0]);
                end
                @(posedge clk); #1;
                // Inputs may wander once the access is accepted.
                if (i < n - 1) begin
                    address = $urandom; write_data = $urandom;
                    wr_en = 1'($urandom); rd_en = 1'($urandom);
                end
            end
            wr_en = 1'b0; rd_en = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_both();
        test_back_to_back();
        test_abort();
        test_wait0();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
